imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Byte-stream program loader that writes instruction memory over a valid/ready byte interface; it is the hardware counterpart of the bench's back-door `$readmemh` preload.
- Holds the CPU in reset while loading.
- Releases the CPU only after a complete, checksum-verified image has been written.
- Sits between an external byte source (UART/debug port) and the CPU, driving the IMem write port and the CPU's active-low reset.

Parameters:
- ADDR_W, 10, word-address width of IMem; maximum image is 2^ADDR_W words.
- BASE_ADDR, 32'h0, byte address of the first loaded word.
- SYNC, 8'hA5, sync byte that starts a frame.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid && in_ready on a rising edge.
- imem_we  out  1  IMem write strobe, one cycle per word.
- imem_addr  out  32  byte address of the word being written (BASE_ADDR + 4*k).
- imem_wdata  out  32  word being written.
- cpu_rstn  out  1  active-low reset to the CPU; low until load succeeds.
- busy  out  1  frame in progress (states LEN_HI to CSUM).
- done  out  1  image loaded, checksum correct.
- error  out  1  frame rejected.
- words_loaded  out  ADDR_W+1  count of words written in the current frame.

Behaviour:
- Reset (reset=0, async): state=IDLE, cpu_rstn=0, imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, busy=0, done=0, error=0, words_loaded=0, in_ready=1. In-flight words are discarded.
- Frame format: SYNC, LEN_HI, LEN_LO, 4*N data bytes, CSUM.
  - N = {LEN_HI, LEN_LO}.
  - Words are big-endian: first byte goes to wdata[31:24].
  - CSUM = XOR of every byte after SYNC (both length bytes and all data bytes).
- IDLE: in_ready=1. Bytes not equal to SYNC are accepted and discarded. SYNC clears the running checksum, clears words_loaded, and moves to LEN_HI.
- LEN_HI: accept a byte, then go to LEN_LO.
- LEN_LO: accept a byte, then evaluate N:
  - N > 2^ADDR_W: go to ERROR.
  - N == 0: go to CSUM.
  - Otherwise: go to DATA.
- DATA: a 2-bit byte counter assembles each word.
  - On acceptance of the 4th byte, the cycle after that edge has imem_we=1 for exactly one cycle, with imem_wdata = the assembled word and imem_addr = BASE_ADDR + 4*words_loaded (pre-increment value).
  - words_loaded increments in that same cycle.
  - After the Nth word, go to CSUM.
  - in_ready stays 1 throughout DATA. Back-to-back bytes are legal: the next word's first byte can be accepted while imem_we is high.
- CSUM: accept a byte and compare it against the running XOR.
  - Match: go to DONE; done=1 and cpu_rstn=1 from the next cycle.
  - Mismatch: go to ERROR.
- DONE and ERROR are terminal: in_ready=0, busy=0. Only reset leaves them.
  - In DONE, cpu_rstn=1.
  - In ERROR, error=1 and cpu_rstn=0, so the CPU never runs a bad image.
- in_valid gaps in any state: state and counters hold, and no strobe is issued.
- Bytes are counted only on in_valid && in_ready.
- imem_we never asserts outside DATA. Words already written before an error stay in IMem; the loader does not scrub them.
- All outputs are registered. in_ready is decoded from the state register.

Test Plan:
- Basic load:
  - Stimulus: A5 00 03, then 20 10 00 09 / 00 00 00 00 / 8C 09 00 40, then CSUM = XOR of those 14 bytes.
  - Required: three imem_we pulses at addresses 0x0, 0x4, 0x8 with data 32'h20100009, 0, 32'h8C090040.
  - Required: words_loaded=3, done=1, and cpu_rstn rises one cycle after CSUM is accepted.
- Bad checksum: same frame with CSUM^1 -> error=1, done=0, cpu_rstn stays 0, in_ready=0 afterwards.
- Leading garbage and valid gaps:
  - Stimulus: 00 FF 5A before A5, then in_valid de-asserted for 3 cycles between data bytes.
  - Required: garbage ignored, identical writes to the basic-load case, no extra strobes.
- Length edge cases:
  - N=0 with CSUM=00 -> done=1, no imem_we.
  - N=1025 with ADDR_W=10 -> error right after LEN_LO, no imem_we.
- Reset mid-load:
  - Stimulus: pull reset low after the second word's imem_we.
  - Required: all outputs return to reset values immediately (asynchronous).
  - Required: a fresh full frame then loads correctly, with words_loaded restarting from 0 at address 0x0.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream handshake between an external source (UART/debug port) and the loader.
interface imem_loader_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream loader: writes IMem word by word and releases the CPU
// reset only after a complete, checksum-verified image has been written.
module imem_loader #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter logic [7:0]  SYNC      = 8'hA5
) (
  input  logic              clock,
  input  logic              reset,
  imem_loader_if.slave      in_if,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rstn,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_HI = 3'd1;
  localparam logic [2:0] S_LEN_LO = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CSUM   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERROR  = 3'd6;

  // Common width for comparing the 16-bit length against the word count.
  localparam int CW = (ADDR_W + 1 > 17) ? ADDR_W + 1 : 17;

  logic [2:0]      state_q, state_d;
  logic [15:0]     len_q, len_d;
  logic [7:0]      csum_q, csum_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic [23:0]     word_q, word_d;
  logic [ADDR_W:0] wl_q, wl_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;

  logic            ready;
  logic            accept;
  logic [15:0]     len_n;
  logic [7:0]      din;

  assign din    = in_if.in_data;
  assign ready  = (state_q != S_DONE) && (state_q != S_ERROR);
  assign accept = in_if.in_valid && ready;
  assign len_n  = {len_q[15:8], din};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    csum_d  = csum_q;
    bcnt_d  = bcnt_q;
    word_d  = word_q;
    wl_d    = wl_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (accept) begin
      case (state_q)
        S_IDLE: begin
          if (din == SYNC) begin
            state_d = S_LEN_HI;
            csum_d  = '0;
            wl_d    = '0;
            bcnt_d  = '0;
          end
        end
        S_LEN_HI: begin
          len_d   = {din, 8'h00};
          csum_d  = csum_q ^ din;
          state_d = S_LEN_LO;
        end
        S_LEN_LO: begin
          len_d  = len_n;
          csum_d = csum_q ^ din;
          if (CW'(len_n) > (CW'(1) << ADDR_W)) state_d = S_ERROR;
          else if (len_n == 16'd0)             state_d = S_CSUM;
          else                                 state_d = S_DATA;
        end
        S_DATA: begin
          csum_d = csum_q ^ din;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            // Address uses the pre-increment count; the count bumps alongside the strobe.
            we_d    = 1'b1;
            wdata_d = {word_q, din};
            addr_d  = BASE_ADDR + (32'(wl_q) << 2);
            wl_d    = wl_q + 1'b1;
            if (CW'(wl_q) + CW'(1) == CW'(len_q)) state_d = S_CSUM;
          end else begin
            word_d = {word_q[15:0], din};
          end
        end
        S_CSUM: begin
          state_d = (din == csum_q) ? S_DONE : S_ERROR;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      csum_q  <= '0;
      bcnt_q  <= '0;
      word_q  <= '0;
      wl_q    <= '0;
      we_q    <= 1'b0;
      addr_q  <= BASE_ADDR;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      csum_q  <= csum_d;
      bcnt_q  <= bcnt_d;
      word_q  <= word_d;
      wl_q    <= wl_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign in_if.in_ready = ready;
  assign imem_we        = we_q;
  assign imem_addr      = addr_q;
  assign imem_wdata     = wdata_q;
  assign words_loaded   = wl_q;
  assign cpu_rstn       = (state_q == S_DONE);
  assign done           = (state_q == S_DONE);
  assign error          = (state_q == S_ERROR);
  assign busy           = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                          (state_q == S_DATA)   || (state_q == S_CSUM);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: framed loads, checksum and length errors,
// stream gaps and asynchronous reset in the middle of a load.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_rstn;
  logic        busy;
  logic        done;
  logic        error;
  logic [10:0] words_loaded;

  imem_loader_if bus ();

  imem_loader #(
    .ADDR_W   (10),
    .BASE_ADDR(32'h0),
    .SYNC     (8'hA5)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_if       (bus),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .cpu_rstn    (cpu_rstn),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int nstrobe  = 0;
  int sb       = 0;
  logic [31:0] s_addr [64];
  logic [31:0] s_data [64];

  // Basic frame: SYNC, N=3, three words, CSUM = FF (hand XOR of the 14 bytes).
  logic [7:0]  fr [16] = '{8'hA5, 8'h00, 8'h03,
                           8'h20, 8'h10, 8'h00, 8'h09,
                           8'h00, 8'h00, 8'h00, 8'h00,
                           8'h8C, 8'h09, 8'h00, 8'h40,
                           8'hFF};
  logic [31:0] ew [3] = '{32'h20100009, 32'h00000000, 32'h8C090040};

  always @(negedge clock) begin
    if (imem_we === 1'b1) begin
      if (nstrobe < 64) begin
        s_addr[nstrobe] = imem_addr;
        s_data[nstrobe] = imem_wdata;
      end
      nstrobe++;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tick(2);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic check_writes(input string pfx);
    check_eq({pfx, "_nstrobe"}, 32'(nstrobe - sb), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("%s_addr%0d", pfx, i), s_addr[sb + i], 32'(i * 4));
      check_eq($sformatf("%s_data%0d", pfx, i), s_data[sb + i], ew[i]);
    end
  endtask

  initial begin
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;
    tick(2);

    // Reset state
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_cpu_rstn", 32'(cpu_rstn), 32'd0);
    check_eq("rst_we", 32'(imem_we), 32'd0);
    check_eq("rst_addr", imem_addr, 32'h0);
    check_eq("rst_wdata", imem_wdata, 32'h0);
    check_eq("rst_flags", {29'd0, busy, done, error}, 32'd0);
    check_eq("rst_words", 32'(words_loaded), 32'd0);
    reset = 1'b1;
    tick(1);

    // Basic load
    sb = nstrobe;
    for (int i = 0; i < 15; i++) send(fr[i]);
    check_eq("basic_pre_cpu_rstn", 32'(cpu_rstn), 32'd0);
    check_eq("basic_pre_busy", 32'(busy), 32'd1);
    send(fr[15]);
    check_eq("basic_done", 32'(done), 32'd1);
    check_eq("basic_cpu_rstn", 32'(cpu_rstn), 32'd1);
    check_eq("basic_err", 32'(error), 32'd0);
    check_eq("basic_busy", 32'(busy), 32'd0);
    check_eq("basic_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("basic_words", 32'(words_loaded), 32'd3);
    check_writes("basic");

    // Bad checksum
    do_reset();
    sb = nstrobe;
    for (int i = 0; i < 15; i++) send(fr[i]);
    send(fr[15] ^ 8'h01);
    tick(3);
    check_eq("bad_error", 32'(error), 32'd1);
    check_eq("bad_done", 32'(done), 32'd0);
    check_eq("bad_cpu_rstn", 32'(cpu_rstn), 32'd0);
    check_eq("bad_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("bad_nstrobe", 32'(nstrobe - sb), 32'd3);

    // Leading garbage and valid gaps
    do_reset();
    sb = nstrobe;
    send(8'h00);
    send(8'hFF);
    send(8'h5A);
    check_eq("gap_idle_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 16; i++) begin
      send(fr[i]);
      if (i == 4) begin
        tick(3);
        check_eq("gap_mid_words", 32'(words_loaded), 32'd0);
        check_eq("gap_mid_we", 32'(imem_we), 32'd0);
      end
      if (i == 10) begin
        tick(3);
        check_eq("gap_w2_words", 32'(words_loaded), 32'd2);
        check_eq("gap_w2_we", 32'(imem_we), 32'd0);
      end
    end
    check_eq("gap_done", 32'(done), 32'd1);
    check_eq("gap_words", 32'(words_loaded), 32'd3);
    check_writes("gap");

    // N = 0 with CSUM = 00
    do_reset();
    sb = nstrobe;
    send(8'hA5);
    send(8'h00);
    send(8'h00);
    send(8'h00);
    tick(1);
    check_eq("n0_done", 32'(done), 32'd1);
    check_eq("n0_cpu_rstn", 32'(cpu_rstn), 32'd1);
    check_eq("n0_nstrobe", 32'(nstrobe - sb), 32'd0);
    check_eq("n0_words", 32'(words_loaded), 32'd0);

    // N = 1025 exceeds 2^10 words
    do_reset();
    sb = nstrobe;
    send(8'hA5);
    send(8'h04);
    check_eq("n1025_pre_error", 32'(error), 32'd0);
    send(8'h01);
    check_eq("n1025_error", 32'(error), 32'd1);
    check_eq("n1025_in_ready", 32'(bus.in_ready), 32'd0);
    check_eq("n1025_busy", 32'(busy), 32'd0);
    for (int i = 0; i < 5; i++) send(8'h11);
    check_eq("n1025_nstrobe", 32'(nstrobe - sb), 32'd0);
    check_eq("n1025_cpu_rstn", 32'(cpu_rstn), 32'd0);

    // Reset mid-load, right after the second word's strobe
    do_reset();
    for (int i = 0; i < 11; i++) send(fr[i]);
    check_eq("mid_we", 32'(imem_we), 32'd1);
    check_eq("mid_words", 32'(words_loaded), 32'd2);
    check_eq("mid_addr", imem_addr, 32'h4);
    #2 reset = 1'b0;
    #1;
    check_eq("mid_rst_we", 32'(imem_we), 32'd0);
    check_eq("mid_rst_words", 32'(words_loaded), 32'd0);
    check_eq("mid_rst_addr", imem_addr, 32'h0);
    check_eq("mid_rst_wdata", imem_wdata, 32'h0);
    check_eq("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_eq("mid_rst_flags", {28'd0, cpu_rstn, busy, done, error}, 32'd0);
    tick(1);
    reset = 1'b1;
    tick(1);
    sb = nstrobe;
    for (int i = 0; i < 16; i++) send(fr[i]);
    check_eq("mid_reload_done", 32'(done), 32'd1);
    check_eq("mid_reload_words", 32'(words_loaded), 32'd3);
    check_writes("mid_reload");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
